// File: rtl/uart_pkg.sv
// Shared constants and types for the UART TX scheduler and its serializer.
package uart_pkg;

  localparam int FRAME_BITS = 10;

  function automatic int clks_per_bit(input int clk_mhz, input int baud);
    return (clk_mhz * 1_000_000) / baud;
  endfunction

  localparam int CLKS_PER_BIT = clks_per_bit(27, 115200);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } sched_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_S0   = 2'b01;
  localparam logic [1:0] GRANT_S1   = 2'b10;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: start bit, 8 data bits LSB first, stop bit.
// The done pulse is one cycle ahead of the frame end so the owner can reload on the stop bit's last edge.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int BIT_CLKS = 234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(BIT_CLKS + 1);

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;
  logic          frame_end;
  logic          load;

  assign bit_end   = (baud_cnt == '0);
  assign frame_end = busy && bit_end && (bit_idx == 4'(FRAME_BITS - 1));
  assign done      = busy && (bit_idx == 4'(FRAME_BITS - 1)) && (baud_cnt == CW'(1));
  assign load      = start && (!busy || frame_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx       <= 1'b1;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else if (load) begin
      tx       <= 1'b0;
      busy     <= 1'b1;
      baud_cnt <= CW'(BIT_CLKS - 1);
      bit_idx  <= '0;
      shreg    <= data;
    end else if (busy) begin
      if (!bit_end) begin
        baud_cnt <= baud_cnt - CW'(1);
      end else if (frame_end) begin
        busy    <= 1'b0;
        tx      <= 1'b1;
        bit_idx <= '0;
      end else begin
        baud_cnt <= CW'(BIT_CLKS - 1);
        bit_idx  <= bit_idx + 4'd1;
        // leaving the last data bit means the stop bit comes next
        if (bit_idx == 4'(FRAME_BITS - 2)) begin
          tx <= 1'b1;
        end else begin
          tx    <= shreg[0];
          shreg <= {1'b0, shreg[7:1]};
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Two-source, packet-granular arbiter in front of a single 8N1 UART transmitter.
//   state | meaning
//   IDLE  | no owner; arbitrate and accept the winner's first byte
//   SEND  | serializer sending a byte for the current owner
//   HOLD  | packet not finished; only the owner may present its next byte
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 27,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel_mode,
  input  logic       s0_valid,
  input  logic [7:0] s0_data,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic [7:0] s1_data,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic       uart_tx,
  output logic       busy,
  output logic [1:0] grant
);

  localparam int BIT_CLKS = clks_per_bit(CLK_FREQ, BAUD_RATE);

  sched_state_t state, state_nxt;
  logic [1:0]   grant_nxt;
  logic         last_q, last_nxt;
  logic         pref_s1, pref_nxt;
  logic         pick_s1;
  logic         start;
  logic [7:0]   start_data;
  logic         done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= GRANT_NONE;
      last_q  <= 1'b0;
      pref_s1 <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      last_q  <= last_nxt;
      pref_s1 <= pref_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    last_nxt   = last_q;
    pref_nxt   = pref_s1;
    pick_s1    = 1'b0;
    s0_ready   = 1'b0;
    s1_ready   = 1'b0;
    start      = 1'b0;
    start_data = s0_data;
    // readies are gated by rst so a source never sees a handshake while the line is held in reset
    if (!rst) begin
      case (state)
        IDLE: begin
          if (s0_valid || s1_valid) begin
            if (sel_mode)                  pick_s1 = s1_valid;
            else if (s0_valid && s1_valid) pick_s1 = pref_s1;
            else                           pick_s1 = s1_valid;
            if (pick_s1) begin
              s1_ready   = 1'b1;
              start_data = s1_data;
              last_nxt   = s1_last;
              grant_nxt  = GRANT_S1;
            end else begin
              s0_ready   = 1'b1;
              start_data = s0_data;
              last_nxt   = s0_last;
              grant_nxt  = GRANT_S0;
            end
            start     = 1'b1;
            state_nxt = SEND;
          end
        end
        SEND: begin
          if (done) begin
            if (last_q) begin
              grant_nxt = GRANT_NONE;
              pref_nxt  = (grant == GRANT_S0);
              state_nxt = IDLE;
            end else begin
              state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          if (grant == GRANT_S1) begin
            s1_ready   = s1_valid;
            start      = s1_valid;
            start_data = s1_data;
            if (s1_valid) last_nxt = s1_last;
          end else begin
            s0_ready   = s0_valid;
            start      = s0_valid;
            start_data = s0_data;
            if (s0_valid) last_nxt = s0_last;
          end
          if (start) state_nxt = SEND;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  uart_tx_serializer #(
    .BIT_CLKS(BIT_CLKS)
  ) u_ser (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .data (start_data),
    .tx   (uart_tx),
    .busy (busy),
    .done (done)
  );

endmodule
